// File: rtl/rob_commit_pkg.sv
// Shared rename-register-file constants and types used by the retire side
// and by the dispatch-stage allocator.
package rob_commit_pkg;

  localparam int RRF_NUM   = 64;
  localparam int RRF_SEL   = $clog2(RRF_NUM);
  localparam int ARF_SEL   = 5;
  localparam int COM_SLOTS = 2;
  localparam int CNT_W     = RRF_SEL + 1;

  typedef logic [RRF_SEL-1:0] rrf_tag_t;
  typedef logic [ARF_SEL-1:0] arf_idx_t;

  typedef struct packed {
    logic     dst_valid;
    arf_idx_t arf;
  } dst_t;

  // Tag 0 is never the first allocation after reset; the allocator starts at 1.
  localparam rrf_tag_t HEAD_RESET = rrf_tag_t'(1);

  function automatic rrf_tag_t tag_add(rrf_tag_t tag, logic [1:0] n);
    return tag + rrf_tag_t'(n);
  endfunction

endpackage

// File: rtl/rob_status_array.sv
// Per-entry valid/done/destination storage for the rename register file,
// with one allocate port, two done-set ports, two clear ports and two reads.
module rob_status_array
  import rob_commit_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       alloc_en,
  input  rrf_tag_t                   alloc_tag,
  input  dst_t                       alloc_dst,
  input  logic     [COM_SLOTS-1:0]   done_en,
  input  rrf_tag_t [COM_SLOTS-1:0]   done_tag,
  input  logic     [COM_SLOTS-1:0]   clr_en,
  input  rrf_tag_t [COM_SLOTS-1:0]   clr_tag,
  input  rrf_tag_t [COM_SLOTS-1:0]   rd_tag,
  output logic     [COM_SLOTS-1:0]   rd_valid,
  output logic     [COM_SLOTS-1:0]   rd_done,
  output dst_t     [COM_SLOTS-1:0]   rd_dst,
  output logic     [RRF_NUM-1:0]     valid_vec
);

  logic [RRF_NUM-1:0] done_vec;
  dst_t               dst_arr [RRF_NUM];

  genvar gi;
  for (gi = 0; gi < RRF_NUM; gi++) begin : g_entry
    logic valid_reg;
    logic done_reg;
    dst_t dst_reg;
    logic hit_alloc;
    logic hit_done;
    logic hit_clr;

    assign hit_alloc = alloc_en && (alloc_tag == rrf_tag_t'(gi));

    always_comb begin
      hit_done = 1'b0;
      hit_clr  = 1'b0;
      for (int s = 0; s < COM_SLOTS; s++) begin
        if (done_en[s] && (done_tag[s] == rrf_tag_t'(gi))) hit_done = 1'b1;
        if (clr_en[s]  && (clr_tag[s]  == rrf_tag_t'(gi))) hit_clr  = 1'b1;
      end
    end

    // Retirement wins over a late done-set; allocation never targets a live entry.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        valid_reg <= 1'b0;
        done_reg  <= 1'b0;
      end else if (hit_clr) begin
        valid_reg <= 1'b0;
        done_reg  <= 1'b0;
      end else if (hit_alloc) begin
        valid_reg <= 1'b1;
        done_reg  <= 1'b0;
      end else if (hit_done) begin
        done_reg  <= 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (hit_alloc) dst_reg <= alloc_dst;
    end

    assign valid_vec[gi] = valid_reg;
    assign done_vec[gi]  = done_reg;
    assign dst_arr[gi]   = dst_reg;
  end

  for (gi = 0; gi < COM_SLOTS; gi++) begin : g_read
    assign rd_valid[gi] = valid_vec[rd_tag[gi]];
    assign rd_done[gi]  = done_vec[rd_tag[gi]];
    assign rd_dst[gi]   = dst_arr[rd_tag[gi]];
  end

endmodule

// File: rtl/rob_commit.sv
// In-order retire stage of the rename register file: commits up to two
// completed entries per cycle and reports the count back to dispatch.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               dp_alloc_en_i,
  input  logic [RRF_SEL-1:0] dp_alloc_tag_i,
  input  logic               dp_dst_valid_i,
  input  logic [ARF_SEL-1:0] dp_dst_arf_i,
  input  logic               wb0_en_i,
  input  logic [RRF_SEL-1:0] wb0_tag_i,
  input  logic               wb1_en_i,
  input  logic [RRF_SEL-1:0] wb1_tag_i,
  output logic [1:0]         com_inst_num_o,
  output logic               com0_en_o,
  output logic               com1_en_o,
  output logic [ARF_SEL-1:0] com0_arf_o,
  output logic [ARF_SEL-1:0] com1_arf_o,
  output logic [RRF_SEL-1:0] com0_rrftag_o,
  output logic [RRF_SEL-1:0] com1_rrftag_o,
  output logic [RRF_SEL-1:0] comptr_o,
  output logic [CNT_W-1:0]   inflight_o,
  output logic               err_o
);

  rrf_tag_t   head_reg, head_next;
  logic [CNT_W-1:0] inflight_reg, inflight_next;
  logic       err_reg, err_next;

  logic [RRF_NUM-1:0]       valid_vec;
  rrf_tag_t [COM_SLOTS-1:0] rd_tag;
  rrf_tag_t [COM_SLOTS-1:0] done_tag;
  logic     [COM_SLOTS-1:0] rd_valid, rd_done, fire, done_en;
  dst_t     [COM_SLOTS-1:0] rd_dst;
  logic       alloc_ok;
  logic       wb_dup;
  logic       err_hit;
  logic [1:0] com_num;

  genvar gi;
  for (gi = 0; gi < COM_SLOTS; gi++) begin : g_slot
    assign rd_tag[gi] = tag_add(head_reg, 2'(gi));
  end

  // Slot 1 may only retire behind slot 0 to keep strict allocation order.
  assign fire[0] = rd_valid[0] & rd_done[0];
  assign fire[1] = fire[0] & rd_valid[1] & rd_done[1];
  assign com_num = 2'(fire[0]) + 2'(fire[1]);

  assign alloc_ok    = dp_alloc_en_i & ~valid_vec[dp_alloc_tag_i];
  assign done_en[0]  = wb0_en_i & valid_vec[wb0_tag_i];
  assign done_en[1]  = wb1_en_i & valid_vec[wb1_tag_i];
  assign done_tag[0] = wb0_tag_i;
  assign done_tag[1] = wb1_tag_i;
  assign wb_dup      = wb0_en_i & wb1_en_i & (wb0_tag_i == wb1_tag_i);
  assign err_hit     = (dp_alloc_en_i & valid_vec[dp_alloc_tag_i])
                     | (wb0_en_i & ~valid_vec[wb0_tag_i])
                     | (wb1_en_i & ~valid_vec[wb1_tag_i])
                     | wb_dup;

  rob_status_array u_status (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .alloc_en  (alloc_ok),
    .alloc_tag (dp_alloc_tag_i),
    .alloc_dst ({dp_dst_valid_i, dp_dst_arf_i}),
    .done_en   (done_en),
    .done_tag  (done_tag),
    .clr_en    (fire),
    .clr_tag   (rd_tag),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_done   (rd_done),
    .rd_dst    (rd_dst),
    .valid_vec (valid_vec)
  );

  always_comb begin
    head_next     = tag_add(head_reg, com_num);
    inflight_next = inflight_reg + CNT_W'(alloc_ok) - CNT_W'(com_num);
    err_next      = err_reg | err_hit;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_reg     <= HEAD_RESET;
      inflight_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      head_reg     <= head_next;
      inflight_reg <= inflight_next;
      err_reg      <= err_next;
    end
  end

  // Destination storage is not reset, so slot fields are gated by the fire bits.
  assign com_inst_num_o = com_num;
  assign com0_en_o      = fire[0] & rd_dst[0].dst_valid;
  assign com1_en_o      = fire[1] & rd_dst[1].dst_valid;
  assign com0_arf_o     = fire[0] ? rd_dst[0].arf : '0;
  assign com1_arf_o     = fire[1] ? rd_dst[1].arf : '0;
  assign com0_rrftag_o  = fire[0] ? rd_tag[0] : '0;
  assign com1_rrftag_o  = fire[1] ? rd_tag[1] : '0;
  assign comptr_o       = head_reg;
  assign inflight_o     = inflight_reg;
  assign err_o          = err_reg;

endmodule

// File: doc/rob_commit.md
# rob_commit

Retire side of the rename register file (RRF): tracks every dispatched RRF entry from allocation to completion, commits up to two completed entries per cycle in strict allocation order, and returns the number freed to the dispatch-stage allocator as `com_inst_num`. Sits between the execute-unit writeback buses, the dispatch allocator, and the architectural register file (ARF) copy port.

## Interface
- `RRF_NUM`, 64: RRF entries; tags are `RRF_SEL` = log2(`RRF_NUM`) = 6 bits.
- `ARF_SEL`, 5: architectural register index width.
- `clk_i`  in  1  clock, all state on rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `dp_alloc_en_i`  in  1  dispatch allocates one entry this cycle.
- `dp_alloc_tag_i`  in  6  tag being allocated; always equals allocator pointer.
- `dp_dst_valid_i`  in  1  instruction writes an architectural register.
- `dp_dst_arf_i`  in  5  destination ARF index.
- `wb0_en_i`, `wb1_en_i`  in  1  execute writeback strobes.
- `wb0_tag_i`, `wb1_tag_i`  in  6  completing RRF tags.
- `com_inst_num_o`  out  2  entries retired this cycle, 0..2.
- `com0_en_o`, `com1_en_o`  out  1  ARF copy request, slot 0 older.
- `com0_arf_o`, `com1_arf_o`  out  5  ARF destination of slot.
- `com0_rrftag_o`, `com1_rrftag_o`  out  6  RRF source tag of slot.
- `comptr_o`  out  6  tag of oldest in-flight entry (head).
- `inflight_o`  out  7  entries allocated and not retired, 0..64.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- Per entry: `valid`, `done`, `dst_valid`, `arf[4:0]`.
- Allocate: `dp_alloc_en_i` sets `valid`, clears `done`, latches dst fields at `dp_alloc_tag_i`.
- Writeback: each `wbN_en_i` sets `done` at its tag; both ports may hit different tags same cycle.
- Commit slot 0 when `valid[head] & done[head]`; slot 1 when slot 0 commits and `valid[head+1] & done[head+1]`.
- `comN_en_o` = slot commits AND `dst_valid`; slot with no destination still retires and counts in `com_inst_num_o`.
- Retiring clears `valid` and `done`; head advances by `com_inst_num_o`.
- Tag arithmetic modulo 64: head 63 advances to 0; head 63 with two commits goes to 0 then 1 (slot 1 tag = 0).
- `inflight_o` next = current + alloc - `com_inst_num_o`; allocate and retire in same cycle both apply.
- Same ARF index in both slots: both issued, slot 1 (younger) is final value; ARF applies slot 1 last.
- `err_o` sets on: allocate to a `valid` entry (overflow); writeback to non-`valid` entry (ignored); both writeback ports same tag (treated as one). Cleared only by reset.

## Timing
- Reset (async assert, sync release): all `valid`/`done` 0, head = 1 (first allocated tag), `inflight_o` 0, `err_o` 0; all commit outputs 0.
- Commit outputs are combinational from registered state only; no input-to-output path.
- Writeback at edge N -> earliest commit visible cycle N+1 -> entry freed at edge ending N+1.
- Allocation at edge N -> writeback legal from cycle N+1.
- Writeback to a tag retiring this cycle cannot occur (not done yet); writeback to the tag being allocated same cycle is flagged and dropped.
- Reset mid-operation discards all in-flight entries immediately; no commit outputs asserted after assert.

## Structure
- `RRF_NUM`, `RRF_SEL`, `ARF_SEL` and commit-slot count live in the shared constants header used by the allocator.
- One sub-module: `rob_status_array` (valid/done/dst storage with 1 set-alloc, 2 set-done, 2 clear ports, 2 read ports at head/head+1).
- Top holds head pointer, in-flight counter, commit select, error logic.

## Test plan
- Reset, allocate tags 1,2,3 with dst 5,6,7, writeback 1 and 2 together -> next cycle `com_inst_num_o`=2, ARF 5/6 from tags 1/2, head=3.
- Writeback tag 2 before tag 1 -> no commit while 1 pending; after wb 1, cycle later commit 1,2 together.
- Fill 64 entries from head 1 through tag 0, retire through wrap -> slot 1 tag 0 when head 63, head becomes 1, `inflight_o` 0.
- Allocate and retire two in same cycle with 10 in flight -> `inflight_o`=9.
- Allocate to valid tag, and wb to invalid tag -> `err_o`=1, state unchanged, sticky until reset.
- Assert `reset_n_i` with 5 done entries mid-cycle -> all commit outputs 0 immediately, head=1 after release.
